risc8_dmem_arbiter: RTL and testbench
=====================================

Name: risc8_dmem_arbiter

Overview:
Shares the single-port 8-bit data memory between the risc8 core's load/store path and a debug/loader port. The core has priority, and the debug port has bounded-latency access. The core is held by a stall strobe when it loses arbitration. The block sits between the core's addr/datapath_out/data_WEN/datapath_in signals and the data RAM.

Parameters:
AW, 8, address width (matches core addr)
DW, 8, data width
MAX_BURST, 4, max consecutive core grants while a debug request waits (range 1-15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
cpu_req  input  1  core requests a data access this cycle
cpu_we  input  1  core access is a write
cpu_addr  input  AW  core address
cpu_wdata  input  DW  core write data
cpu_rdata  output  DW  core read data, valid cycle after granted read
cpu_stall  output  1  core must hold its request and freeze PC/state
dbg_req  input  1  debug request; held until dbg_ack
dbg_we  input  1  debug access is a write
dbg_addr  input  AW  debug address
dbg_wdata  input  DW  debug write data
dbg_rdata  output  DW  registered debug read data
dbg_ack  output  1  one-cycle completion pulse
mem_addr  output  AW  RAM address
mem_wdata  output  DW  RAM write data
mem_we  output  1  RAM write enable
mem_rdata  input  DW  RAM read data, 1-cycle synchronous-read latency
grant_dbg  output  1  debug owns the RAM this cycle (observability)

Behaviour:
- Reset (reset=0 at clk edge): owner=IDLE, burst_cnt=0, dbg_ack=0, dbg_rdata=0. While reset=0: cpu_stall=0, mem_we=0, grant_dbg=0, no grants.
- dbg_pend = dbg_req & ~dbg_ack. This prevents regranting a request in its ack cycle.
- Grant rule, combinational per cycle:
  - Debug is granted if dbg_pend and (~cpu_req or burst_cnt==MAX_BURST).
  - Otherwise the core is granted if cpu_req.
  - Otherwise there is no grant.
- Mux, combinational from grant: mem_addr/mem_wdata come from the granted requester; mem_we = granted requester's we. With no grant: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=0.
- cpu_stall = cpu_req & grant_dbg. The core re-presents the identical request next cycle.
- owner register (IDLE/CPU_RD/DBG_RD/WR) records last cycle's grant type and routes returning read data:
  - CPU_RD: cpu_rdata = mem_rdata (passthrough, same latency as a direct RAM hookup).
  - DBG_RD: dbg_rdata <= mem_rdata at the next edge.
  - cpu_rdata = mem_rdata in every state; the core only samples it after a granted read.
- dbg_ack: registered, asserted for exactly one cycle, the cycle after the debug grant. For reads, dbg_rdata is updated in that same cycle and holds until the next completed debug read. Debug writes do not alter dbg_rdata.
- burst_cnt:
  - Increments (saturating at MAX_BURST) on each core grant while dbg_pend=1.
  - Cleared on debug grant or when dbg_pend=0.
  - Worst-case debug latency from dbg_req to grant is MAX_BURST cycles; to ack, MAX_BURST+1.
- Back-to-back debug: dbg_req may stay high across ack for a new transaction. The new request is eligible the cycle after ack.
- Reset mid-transaction: a pending ack or DBG_RD capture is discarded, and dbg_ack does not fire.
- Request inputs are assumed stable while cpu_stall or dbg_pend is asserted. The arbiter does not check this.

Optional Feature:
RISC8_DBG_LOCK_EN
- Defined: adds input dbg_lock (1 bit). While grant_dbg=1 and dbg_lock=1, ownership is latched to debug. Every cycle with dbg_req=1 is granted to debug (regrant allowed in the ack cycle), and cpu_stall=cpu_req, regardless of burst_cnt. The lock releases the cycle after dbg_lock or dbg_req falls. This gives atomic multi-byte patching.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset: hold reset=0 for 2 cycles with cpu_req=1, dbg_req=1 -> mem_we=0, cpu_stall=0, dbg_ack=0, dbg_rdata=0x00.
- Core only: write 0x5A to 0x10, then read 0x10 -> mem_we=1 on the write cycle; cpu_rdata=0x5A the cycle after the read grant; cpu_stall never 1.
- Debug only: dbg read of 0x10 (RAM=0xC3) -> grant_dbg=1 in cycle 0; dbg_ack=1 and dbg_rdata=0xC3 in cycle 1; no regrant in cycle 1.
- Contention, MAX_BURST=4: cpu_req held continuously, dbg_req raised at cycle 0 -> core granted cycles 0-3, debug granted cycle 4 with cpu_stall=1, dbg_ack at cycle 5, core resumes cycle 5.
- Reset mid-op: debug read granted, reset=0 on the next edge -> dbg_ack stays 0, dbg_rdata=0x00, owner=IDLE.
- With RISC8_DBG_LOCK_EN: dbg_lock=1, dbg_req held 3 cycles with writes 0x01/0x02/0x03 to 0x20-0x22 -> 3 consecutive debug grants, cpu_stall=1 throughout, RAM holds 0x01,0x02,0x03.

Source files
------------

// File: rtl/risc8_dmem_arbiter.sv
// Purpose : shares the risc8 single-port data RAM between the core load/store path and a debug/loader port.
// Latency : grant is combinational; core read data is a RAM passthrough; debug ack/read data arrive one cycle after the debug grant.
// Backpressure: a core request that loses arbitration is held by cpu_stall; a debug request waits at most MAX_BURST core grants.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-low reset (0 = reset)
//   cpu_req/we/addr/wdata: core access request; re-presented unchanged while cpu_stall=1
//   cpu_rdata            : core read data (RAM passthrough, valid the cycle after a granted read)
//   cpu_stall            : core lost arbitration this cycle and must freeze
//   dbg_req/we/addr/wdata: debug access request, held until dbg_ack
//   dbg_lock             : (only with RISC8_DBG_LOCK_EN) keeps the RAM owned by debug
//   dbg_rdata, dbg_ack   : debug read data and one-cycle completion pulse
//   mem_addr/wdata/we    : RAM command side
//   mem_rdata            : RAM read data, one-cycle synchronous read latency
//   grant_dbg            : debug owns the RAM this cycle
//
// Optional build macro: RISC8_DBG_LOCK_EN adds the dbg_lock input for atomic multi-byte debug sequences.

module risc8_dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4   // 1..15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
`ifdef RISC8_DBG_LOCK_EN
  input  logic          dbg_lock,
`endif
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_dbg
);

  localparam int            CW        = 4;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  // What the RAM was doing last cycle; decides where returning read data goes.
  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_DBG_RD = 2'd2,
    OWN_WR     = 2'd3
  } owner_e;

  owner_e        owner_q,     owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          dbg_ack_q,   dbg_ack_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic dbg_pend;
  logic burst_full;
  logic lock_hold;
  logic gnt_dbg;
  logic gnt_cpu;

  // ---------------------------------------------------------------------------
  // Debug lock: once a locked debug access is granted, every following cycle
  // with dbg_req high goes to debug (even the ack cycle) until lock or req drops.
  // ---------------------------------------------------------------------------
`ifdef RISC8_DBG_LOCK_EN
  logic lock_q, lock_d;

  always_comb begin
    lock_hold = lock_q & dbg_req;
    lock_d    = gnt_dbg & dbg_lock;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  always_comb begin
    lock_hold = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // A request in its own ack cycle is already served; masking it here keeps
    // a held dbg_req from being granted twice.
    dbg_pend   = dbg_req & ~dbg_ack_q;
    burst_full = (burst_cnt_q == BURST_MAX);

    gnt_dbg = reset & (lock_hold | (dbg_pend & (~cpu_req | burst_full)));
    gnt_cpu = reset & ~gnt_dbg & cpu_req;
  end

  // ---------------------------------------------------------------------------
  // RAM command mux and core-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr  = gnt_dbg ? dbg_addr  : cpu_addr;
    mem_wdata = gnt_dbg ? dbg_wdata : cpu_wdata;
    mem_we    = gnt_dbg ? dbg_we    : (gnt_cpu & cpu_we);
    cpu_stall = cpu_req & gnt_dbg;
    grant_dbg = gnt_dbg;
  end

  // Core read data is a straight passthrough so the core sees the same timing
  // as with the RAM wired directly; it only samples after its own granted read.
  assign cpu_rdata = mem_rdata;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d     = OWN_IDLE;
    burst_cnt_d = burst_cnt_q;
    dbg_ack_d   = gnt_dbg;
    dbg_rdata_d = dbg_rdata_q;

    if (gnt_dbg) begin
      owner_d = dbg_we ? OWN_WR : OWN_DBG_RD;
    end else if (gnt_cpu) begin
      owner_d = cpu_we ? OWN_WR : OWN_CPU_RD;
    end

    // Counts core grants that overtook a waiting debug request; once it hits
    // MAX_BURST the debug side wins the next cycle.
    if (gnt_dbg || !dbg_pend) begin
      burst_cnt_d = '0;
    end else if (gnt_cpu && !burst_full) begin
      burst_cnt_d = burst_cnt_q + CW'(1);
    end

    if (owner_q == OWN_DBG_RD) begin
      dbg_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q     <= OWN_IDLE;
      burst_cnt_q <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debug completion
  // ---------------------------------------------------------------------------
  // The RAM only returns data in the ack cycle, so the read value is forwarded
  // from mem_rdata during that cycle and held from the register afterwards;
  // the debugger therefore sees valid data together with dbg_ack.
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = (owner_q == OWN_DBG_RD) ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_risc8_dmem_arbiter.sv
module tb_risc8_dmem_arbiter;

  localparam int MAXB = 4;
  localparam int L_NONE = 0, L_CPURD = 1, L_DBGRD = 2, L_WR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic       dbg_lock;
  logic       dbg_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       grant_dbg;

  always #5 clk = ~clk;

  risc8_dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
`ifdef RISC8_DBG_LOCK_EN
    .dbg_lock  (dbg_lock),
`endif
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .grant_dbg (grant_dbg)
  );

  // Synchronous-read RAM (read-first), filled with a known pattern on the first edge.
  logic [7:0] ram [0:255];
  bit         ram_ready;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who must own the RAM this cycle, and what each requester
  // must see next, straight from the arbitration rules.
  // ---------------------------------------------------------------------------
  bit         model_on = 1'b0;
  bit         m_ack;      // a debug grant happened last cycle
  int         m_cnt;      // core grants since debug started waiting
  int         m_last;     // kind of access granted last cycle
  logic [7:0] m_val;      // RAM contents at the address granted last cycle
  logic [7:0] m_rdata;    // last completed debug read value
  bit         m_lock;

  logic m_gd, m_gc;
  assign m_gd = reset && ((m_lock && dbg_req) ||
                          (dbg_req && !m_ack && (!cpu_req || m_cnt == MAXB)));
  assign m_gc = reset && !m_gd && cpu_req;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_ack = 0; m_cnt = 0; m_last = L_NONE; m_rdata = 8'h00; m_lock = 0;
      model_on = 1'b1;
    end else begin
      if (m_last == L_DBGRD) m_rdata = m_val;
      if (m_gd || !(dbg_req && !m_ack)) m_cnt = 0;
      else if (m_gc && m_cnt < MAXB) m_cnt = m_cnt + 1;
      m_lock = m_gd && dbg_lock;
      m_ack  = m_gd;
      if (m_gd) begin
        m_last = dbg_we ? L_WR : L_DBGRD;
        m_val  = ram[dbg_addr];
      end else if (m_gc) begin
        m_last = cpu_we ? L_WR : L_CPURD;
        m_val  = ram[cpu_addr];
      end else begin
        m_last = L_NONE;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("grant_dbg", grant_dbg, m_gd);
      chk("cpu_stall", cpu_stall, cpu_req && m_gd);
      chk("mem_we",    mem_we,    m_gd ? dbg_we : (m_gc && cpu_we));
      chk("mem_addr",  mem_addr,  m_gd ? dbg_addr : cpu_addr);
      chk("mem_wdata", mem_wdata, m_gd ? dbg_wdata : cpu_wdata);
      chk("dbg_ack",   dbg_ack,   m_ack);
      chk("cpu_rdata_pass", cpu_rdata, mem_rdata);
      if (m_last == L_CPURD) chk("cpu_rdata_val", cpu_rdata, m_val);
      chk("dbg_rdata", dbg_rdata, (m_last == L_DBGRD) ? m_val : m_rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios with literal expectations, then randomized traffic.
  // ---------------------------------------------------------------------------
  initial begin : stim
    bit stall_seen, ack_seen, was_rst, dbg_busy;

    reset = 1'b0; dbg_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hAA;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h11; dbg_wdata = 8'hBB;

    // Reset held two cycles with both sides requesting.
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall",  cpu_stall, 0);
    chk("rst_grant",  grant_dbg, 0);
    cyc(); @(negedge clk);
    chk("rst_ack",       dbg_ack, 0);
    chk("rst_dbg_rdata", dbg_rdata, 8'h00);
    chk("rst_mem_we2",   mem_we, 0);
    cyc(); reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;

    // Core only: write 0x5A to 0x10, read it back.
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
    @(negedge clk);
    chk("core_wr_we",    mem_we, 1);
    chk("core_wr_addr",  mem_addr, 8'h10);
    chk("core_wr_stall", cpu_stall, 0);
    cyc(); cpu_we = 1'b0;
    @(negedge clk);
    chk("core_rd_we", mem_we, 0);
    cyc(); cpu_req = 1'b0;
    @(negedge clk);
    chk("core_rdata", cpu_rdata, 8'h5A);

    // Debug only: write 0xC3 to 0x10, then back-to-back read of it.
    cyc(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 8'hC3;
    @(negedge clk);
    chk("dbg_wr_grant", grant_dbg, 1);
    chk("dbg_wr_data",  mem_wdata, 8'hC3);
    cyc();
    @(negedge clk);
    chk("dbg_wr_ack",     dbg_ack, 1);
    chk("dbg_wr_noregnt", grant_dbg, 0);
    cyc(); dbg_we = 1'b0;
    @(negedge clk);
    chk("dbg_rd_grant", grant_dbg, 1);
    chk("dbg_rd_we",    mem_we, 0);
    cyc();
    @(negedge clk);
    chk("dbg_rd_ack",     dbg_ack, 1);
    chk("dbg_rd_data",    dbg_rdata, 8'hC3);
    chk("dbg_rd_noregnt", grant_dbg, 0);
    cyc(); dbg_req = 1'b0;
    @(negedge clk);
    chk("dbg_rd_hold", dbg_rdata, 8'hC3);
    chk("dbg_ack_one", dbg_ack, 0);

    // Contention: core requests continuously, debug waits MAX_BURST grants.
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'h77;
    for (int i = 0; i < MAXB; i++) begin
      @(negedge clk);
      chk("cont_core_grant", grant_dbg, 0);
      chk("cont_core_stall", cpu_stall, 0);
      cyc();
    end
    @(negedge clk);
    chk("cont_dbg_grant", grant_dbg, 1);
    chk("cont_dbg_stall", cpu_stall, 1);
    cyc();
    @(negedge clk);
    chk("cont_ack",         dbg_ack, 1);
    chk("cont_core_resume", grant_dbg, 0);
    chk("cont_no_stall",    cpu_stall, 0);
    cyc(); cpu_req = 1'b0; dbg_req = 1'b0;

    // Reset lands on the edge after a debug read grant.
    cyc(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
    @(negedge clk);
    chk("midrst_grant", grant_dbg, 1);
    #1 reset = 1'b0;
    cyc(); dbg_req = 1'b0;
    @(negedge clk);
    chk("midrst_ack",   dbg_ack, 0);
    chk("midrst_rdata", dbg_rdata, 8'h00);
    cyc(); reset = 1'b1;

`ifdef RISC8_DBG_LOCK_EN
    // Locked debug patch of three bytes while the core keeps requesting.
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h01; dbg_lock = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!grant_dbg && n < 20) begin
        cyc(); @(negedge clk); n++;
      end
    end
    chk("lock_g0", grant_dbg, 1);
    chk("lock_s0", cpu_stall, 1);
    cyc(); dbg_addr = 8'h21; dbg_wdata = 8'h02;
    @(negedge clk);
    chk("lock_g1", grant_dbg, 1);
    chk("lock_s1", cpu_stall, 1);
    cyc(); dbg_addr = 8'h22; dbg_wdata = 8'h03;
    @(negedge clk);
    chk("lock_g2", grant_dbg, 1);
    chk("lock_s2", cpu_stall, 1);
    cyc(); dbg_req = 1'b0; dbg_lock = 1'b0; cpu_req = 1'b0;
    cyc();
    @(negedge clk);
    chk("lock_ram20", ram[8'h20], 8'h01);
    chk("lock_ram21", ram[8'h21], 8'h02);
    chk("lock_ram22", ram[8'h22], 8'h03);
`endif

    // Randomized traffic obeying the request-hold rules.
    dbg_busy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      stall_seen = cpu_stall;
      ack_seen   = dbg_ack;
      was_rst    = !reset;
      cyc();
      reset = ($urandom_range(0, 249) != 0);
      if (was_rst) dbg_busy = 1'b0;
      if (!stall_seen || was_rst) begin
        cpu_req   = ($urandom_range(0, 9) < 7);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 8'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end
      if (!dbg_busy || ack_seen) begin
        dbg_req   = ($urandom_range(0, 9) < 4);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 8'($urandom_range(0, 31));
        dbg_wdata = 8'($urandom);
        dbg_busy  = dbg_req;
`ifdef RISC8_DBG_LOCK_EN
        dbg_lock  = ($urandom_range(0, 3) == 0);
`endif
      end
    end

    cyc(); reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
